// File: rtl/dm_pkg.sv
// Shared encodings, FSM state type and access-size helpers for the data-memory access controller.
package dm_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MERGE = 2'd2
  } state_t;

  // Encodings 101-111 fall through to a full-word access.
  function automatic logic is_half(input logic [2:0] t);
    return (t == DM_HALF) || (t == DM_HALF_U);
  endfunction

  function automatic logic is_byte(input logic [2:0] t);
    return (t == DM_BYTE) || (t == DM_BYTE_U);
  endfunction

  function automatic logic is_word(input logic [2:0] t);
    return !(is_half(t) || is_byte(t));
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational lane handling: extract and extend load data, and merge sub-word store data into a word.
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [2:0]  dmtype,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    byte_sel   = word[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? word[31:16] : word[15:0];
    load_data  = word;
    merge_data = wdata;

    case (dmtype)
      DM_HALF:   load_data = {{16{half_sel[15]}}, half_sel};
      DM_HALF_U: load_data = {16'h0000, half_sel};
      DM_BYTE:   load_data = {{24{byte_sel[7]}}, byte_sel};
      DM_BYTE_U: load_data = {24'h000000, byte_sel};
      default:   load_data = word;
    endcase

    if (is_half(dmtype)) begin
      merge_data = word;
      if (offset[1]) merge_data[31:16] = wdata[15:0];
      else           merge_data[15:0]  = wdata[15:0];
    end else if (is_byte(dmtype)) begin
      merge_data = word;
      merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory sequencer: word stores in one cycle, loads and sub-word stores (read-modify-write) in two.
// Optional misalignment trapping is enabled with the DM_MISALIGN_CHK_EN macro.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        dmtype,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              misalign,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t            state, next_state;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        dmtype_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              issue;
  logic              misaligned;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef DM_MISALIGN_CHK_EN
  assign misaligned = is_word(dmtype) ? (addr[1:0] != 2'b00)
                    : is_half(dmtype) ? addr[0]
                    : 1'b0;
`else
  assign misaligned = 1'b0;
`endif

  // Gating with rst keeps every output at 0 while reset is held, not just after the edge.
  assign issue = ~rst & req & (state == IDLE);

  dm_lane_fmt u_lane_fmt (
    .dmtype     (dmtype_q),
    .offset     (addr_q[1:0]),
    .word       (ram_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    next_state = state;
    rdata      = '0;
    done       = 1'b0;
    stall      = 1'b0;
    misalign   = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;

    case (state)
      IDLE: begin
        if (issue) begin
          if (misaligned) begin
            done     = 1'b1;
            misalign = 1'b1;
          end else if (we && is_word(dmtype)) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = addr[ADDR_W+1:2];
            ram_wdata = wdata;
            done      = 1'b1;
          end else begin
            ram_en     = 1'b1;
            ram_addr   = addr[ADDR_W+1:2];
            stall      = 1'b1;
            next_state = we ? MERGE : LOAD;
          end
        end
      end
      LOAD: begin
        done       = 1'b1;
        rdata      = we_q ? 32'h0 : load_data;
        next_state = IDLE;
      end
      MERGE: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = addr_q[ADDR_W+1:2];
        ram_wdata  = merge_data;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      dmtype_q <= DM_WORD;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (issue) begin
        addr_q   <= addr[ADDR_W+1:0];
        dmtype_q <= dmtype;
        wdata_q  <= wdata;
        we_q     <= we;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl with a behavioural synchronous RAM.
module tb_dm_access_ctrl;
  import dm_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              we;
  logic [2:0]        dmtype;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              stall;
  logic              misalign;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .dmtype    (dmtype),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .stall     (stall),
    .misalign  (misalign),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; dmtype = t; addr = a; wdata = d;
  endtask

  // Two-cycle load; the second cycle scrambles the request inputs to prove latched copies are used.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] t,
                         input logic [31:0] exp, input logic hold);
    @(negedge clk);
    drive(1'b1, 1'b0, t, a, 32'hFFFF_FFFF);
    #1;
    check({tag, "_stall"}, stall, 1);
    check({tag, "_en"}, ram_en, 1);
    check({tag, "_we"}, ram_we, 0);
    check({tag, "_idx"}, ram_addr, a[ADDR_W+1:2]);
    check({tag, "_done0"}, done, 0);
    check({tag, "_mis"}, misalign, 0);
    @(negedge clk);
    drive(hold, 1'b1, DM_WORD, 32'h0000_0000, 32'h0);
    #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_stall1"}, stall, 0);
    check({tag, "_en1"}, ram_en, 0);
  endtask

  task automatic do_sub_store(input string tag, input logic [31:0] a, input logic [2:0] t,
                              input logic [31:0] d, input logic [31:0] exp_word);
    @(negedge clk);
    drive(1'b1, 1'b1, t, a, d);
    #1;
    check({tag, "_stall"}, stall, 1);
    check({tag, "_rd_en"}, ram_en, 1);
    check({tag, "_rd_we"}, ram_we, 0);
    check({tag, "_done0"}, done, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, DM_WORD, 32'h0, 32'h0);
    #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_wr_we"}, ram_we, 1);
    check({tag, "_wr_idx"}, ram_addr, a[ADDR_W+1:2]);
    check({tag, "_wr_data"}, ram_wdata, exp_word);
    check({tag, "_stall1"}, stall, 0);
    check({tag, "_rdata0"}, rdata, 0);
    @(posedge clk);
    #1;
    check({tag, "_mem"}, mem[a[ADDR_W+1:2]], exp_word);
  endtask

  task automatic do_word_store(input string tag, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(1'b1, 1'b1, DM_WORD, a, d);
    #1;
    check({tag, "_stall"}, stall, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_we"}, ram_we, 1);
    check({tag, "_idx"}, ram_addr, a[ADDR_W+1:2]);
    check({tag, "_wdata"}, ram_wdata, d);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    mem[1]    = 32'h8899_AABB;
    ram_rdata = 32'h0;
    rst = 1'b1;
    drive(1'b1, 1'b0, DM_BYTE, 32'h7, 32'h0);

    // Outputs must stay 0 while reset is held, even with a request pending.
    @(negedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_en", ram_en, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mis", misalign, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, DM_WORD, 32'h0, 32'h0);

    do_load("lb7",  32'h7, DM_BYTE,   32'hFFFF_FF88, 1'b0);
    do_load("lbu7", 32'h7, DM_BYTE_U, 32'h0000_0088, 1'b1);
    do_load("lhu6", 32'h6, DM_HALF_U, 32'h0000_8899, 1'b0);
    do_load("lh4",  32'h4, DM_HALF,   32'hFFFF_AABB, 1'b0);
    do_load("lw5t", 32'h4, 3'b101,    32'h8899_AABB, 1'b0);

    do_sub_store("sb5", 32'h5, DM_BYTE, 32'h1234_5655, 32'h8899_55BB);
    do_sub_store("sh6", 32'h6, DM_HALF, 32'h0000_CAFE, 32'hCAFE_55BB);

    do_word_store("sw8a", 32'h8, 32'hDEAD_BEEF);
    do_word_store("sw8b", 32'h8, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b0, 1'b0, DM_WORD, 32'h0, 32'h0);
    #1;
    check("sw8_mem", mem[2], 32'hDEAD_BEEF);

    // Reset during MERGE: the write must never reach the RAM.
    @(negedge clk);
    drive(1'b1, 1'b1, DM_BYTE, 32'h4, 32'h0000_0077);
    #1;
    check("rm_stall", stall, 1);
    @(negedge clk);
    drive(1'b0, 1'b0, DM_WORD, 32'h0, 32'h0);
    #1;
    check("rm_merge_we", ram_we, 1);
    rst = 1'b1;
    #1;
    check("rm_rst_we", ram_we, 0);
    check("rm_rst_en", ram_en, 0);
    check("rm_rst_done", done, 0);
    check("rm_rst_wdata", ram_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rm_mem", mem[1], 32'hCAFE_55BB);
    do_load("rm_lw4", 32'h4, DM_WORD, 32'hCAFE_55BB, 1'b0);

`ifdef DM_MISALIGN_CHK_EN
    @(negedge clk);
    drive(1'b1, 1'b0, DM_WORD, 32'h6, 32'h0);
    #1;
    check("mis_flag", misalign, 1);
    check("mis_done", done, 1);
    check("mis_en", ram_en, 0);
    check("mis_stall", stall, 0);
    check("mis_rdata", rdata, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, DM_WORD, 32'h0, 32'h0);
    #1;
    check("mis_idle", done, 0);
`else
    do_load("lw6", 32'h6, DM_WORD, 32'hCAFE_55BB, 1'b0);
`endif

    @(negedge clk);
    drive(1'b0, 1'b0, DM_WORD, 32'h0, 32'h0);
    #1;
    check("end_idle_done", done, 0);
    check("end_idle_en", ram_en, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
